// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus router: FSM state encoding,
// request payload, default slave address map and the error read-data value.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned DEF_NSLV = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

    // Request fields captured on accept and replayed to the selected slave
    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wren;
    } bus_req_t;

    // Slave 0 occupies the least significant 32 bits
    localparam logic [DEF_NSLV*ADDR_W-1:0] DEF_SLV_BASE = {
        32'h8000_0100, 32'h8000_0000, 32'h0002_0000, 32'h0000_0000
    };
    localparam logic [DEF_NSLV*ADDR_W-1:0] DEF_SLV_MASK = {
        32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000
    };

    localparam logic [DATA_W-1:0] ERR_DATA = '0;

    function automatic logic addr_match(
        input logic [ADDR_W-1:0] adr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] mask
    );
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Slave-wait watchdog: counts enabled cycles and flags the TIMEOUT-th one.
// Instantiated by cpu_bus_router only when BUS_TIMEOUT_EN is defined.
module bus_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Expiry is combinational so the FSM leaves on the last allowed cycle
    assign o_expired_c = i_enable && (r_cnt == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_router.sv
// Single-master CPU bus router: address decode to NSLV slaves, IDLE/ACCESS/DONE
// handshake. Optional slave-wait timeout enabled by defining BUS_TIMEOUT_EN.
module cpu_bus_router
    import cpu_bus_pkg::*;
#(
    parameter int unsigned              NSLV     = DEF_NSLV,
    parameter logic [NSLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned              TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_mem_op,
    input  logic [ADDR_W-1:0]       cpu_adr,
    input  logic [DATA_W-1:0]       cpu_do,
    input  logic [STRB_W-1:0]       cpu_wren,
    output logic                    cpu_mem_rdy,
    output logic [DATA_W-1:0]       cpu_di,
    output logic                    cpu_err,
    output logic [NSLV-1:0]         slv_sel,
    output logic [ADDR_W-1:0]       slv_adr,
    output logic [DATA_W-1:0]       slv_do,
    output logic [STRB_W-1:0]       slv_wren,
    input  logic [NSLV-1:0]         slv_rdy,
    input  logic [NSLV*DATA_W-1:0]  slv_di
);

    localparam int unsigned IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    // Elaboration-time range check on the configuration
    if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
        $error("cpu_bus_router: NSLV or TIMEOUT out of range");
    end

    bus_state_e         r_state;
    bus_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    bus_req_t           r_req;
    bus_req_t           w_req_nxt;
    logic [NSLV-1:0]    r_sel;
    logic [NSLV-1:0]    w_sel_nxt;
    logic               r_rdy;
    logic               w_rdy_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [DATA_W-1:0]  r_di;
    logic [DATA_W-1:0]  w_di_nxt;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_slv_done;
    logic [DATA_W-1:0]  w_slv_rdata;
    logic               w_tmo_expired;

    // Address decode; walking downwards lets the lowest matching index win
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (addr_match(cpu_adr, SLV_BASE[i*ADDR_W +: ADDR_W], SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Read data from the slave latched at accept time
    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_slv_rdata = slv_di[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready from any slave other than the selected one is masked off
    assign w_slv_done = |(slv_rdy & r_sel);

`ifdef BUS_TIMEOUT_EN
    bus_timeout #(
        .TIMEOUT     (TIMEOUT)
    ) u_timeout (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_state != ST_ACCESS),
        .i_enable    (r_state == ST_ACCESS),
        .o_expired_c (w_tmo_expired)
    );
`else
    assign w_tmo_expired = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_req_nxt   = r_req;
        w_sel_nxt   = '0;
        w_rdy_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_di_nxt    = r_di;

        case (r_state)
            ST_IDLE: begin
                if (cpu_mem_op) begin
                    if (w_hit) begin
                        w_state_nxt   = ST_ACCESS;
                        w_idx_nxt     = w_hit_idx;
                        w_req_nxt.adr   = cpu_adr;
                        w_req_nxt.wdata = cpu_do;
                        w_req_nxt.wren  = cpu_wren;
                        w_sel_nxt     = NSLV'(1) << w_hit_idx;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_rdy_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_di_nxt    = ERR_DATA;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_slv_done) begin
                    w_state_nxt = ST_DONE;
                    w_rdy_nxt   = 1'b1;
                    w_di_nxt    = (r_req.wren != '0) ? DATA_W'(0) : w_slv_rdata;
                end else if (w_tmo_expired) begin
                    w_state_nxt = ST_DONE;
                    w_rdy_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_di_nxt    = ERR_DATA;
                end else begin
                    w_sel_nxt = r_sel;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_req   <= '0;
            r_sel   <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_di    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_req   <= w_req_nxt;
            r_sel   <= w_sel_nxt;
            r_rdy   <= w_rdy_nxt;
            r_err   <= w_err_nxt;
            r_di    <= w_di_nxt;
        end
    end

    assign cpu_mem_rdy = r_rdy;
    assign cpu_err     = r_err;
    assign cpu_di      = r_di;
    assign slv_sel     = r_sel;
    assign slv_adr     = r_req.adr;
    assign slv_do      = r_req.wdata;
    assign slv_wren    = r_req.wren;

endmodule

// File: doc/cpu_bus_router.md
CPU_BUS_ROUTER -- requirements
Module: cpu_bus_router

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of slave ports (1..8).
REQ-002 SHALL have parameter SLV_BASE, default {0x80000100,0x80000000,0x00020000,0x00000000}, packed NSLV×32 base addresses (slave 0 in LSBs).
REQ-003 SHALL have parameter SLV_MASK, default {0xFFFFFF00,0xFFFFFF00,0xFFFF0000,0xFFFF0000}, packed NSLV×32 decode masks.
REQ-004 SHALL have parameter TIMEOUT, default 255, slave-wait cycle limit (1..65535).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports cpu_mem_op in 1 (request valid), cpu_adr in 32, cpu_do in 32 (write data), cpu_wren in 4 (byte strobes, 0 = read).
REQ-008 SHALL have ports cpu_mem_rdy out 1 (completion), cpu_di out 32 (read data), cpu_err out 1 (bus error, valid with cpu_mem_rdy).
REQ-009 SHALL have ports slv_sel out NSLV (one-hot select), slv_adr out 32, slv_do out 32, slv_wren out 4.
REQ-010 SHALL have ports slv_rdy in NSLV (per-slave completion), slv_di in NSLV×32 (per-slave read data).

Function
REQ-011 SHALL decode slave i when (cpu_adr & SLV_MASK[i]) == SLV_BASE[i]; on multiple hits, the lowest index wins.
REQ-012 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-013 SHALL, in IDLE with cpu_mem_op=1 and a hit, register index, cpu_adr, cpu_do, cpu_wren and go to ACCESS.
REQ-014 SHALL, in IDLE with cpu_mem_op=1 and no hit, go to DONE with error flag set and read data 0.
REQ-015 SHALL, in ACCESS, drive slv_sel one-hot at the registered index; slv_adr/slv_do/slv_wren hold registered values until ACCESS is left.
REQ-016 SHALL, in ACCESS, capture slv_di[index] when slv_rdy[index]=1 and go to DONE; slv_rdy of unselected slaves is ignored.
REQ-017 SHALL, in DONE, assert cpu_mem_rdy for exactly one cycle with cpu_di/cpu_err valid, then return to IDLE.
REQ-018 SHALL keep cpu_mem_rdy, cpu_err and slv_sel at 0 outside DONE/ACCESS respectively; cpu_di SHALL hold its last value.
REQ-019 SHALL give a minimum latency of 2 cycles from sampled cpu_mem_op to cpu_mem_rdy (slave ready in first ACCESS cycle); unmapped access SHALL complete in 1 cycle.
REQ-020 SHALL complete a transaction once accepted even if cpu_mem_op drops; a new request SHALL NOT be accepted in DONE.
REQ-021 SHALL, on a write, return cpu_di = 0.

Reset
REQ-022 SHALL, on reset low, asynchronously enter IDLE and clear all outputs and registers to 0, aborting any transaction in flight.
REQ-023 SHALL sample requests from the first rising clk edge after reset deasserts.

Configuration
REQ-024 SHALL compile timeout logic only when BUS_TIMEOUT_EN is defined.
REQ-025 SHALL, with BUS_TIMEOUT_EN, count ACCESS cycles; after TIMEOUT cycles without slv_rdy, go to DONE with cpu_err=1, cpu_di=0, slv_sel deasserted.
REQ-026 SHALL, without BUS_TIMEOUT_EN, wait in ACCESS indefinitely; cpu_err then SHALL only flag unmapped addresses.

Structure
REQ-027 SHALL take the FSM state enum, default base/mask constants and the 0 error-data value from shared package cpu_bus_pkg.
REQ-028 SHALL place the timeout counter (clear, enable, expired) in sub-module bus_timeout, instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-029 Read 0x00000010, slave0 rdy on first ACCESS cycle with slv_di=0x12345678 -> cpu_mem_rdy 2 cycles after request, cpu_di=0x12345678, cpu_err=0.
REQ-030 Write 0x80000104, wren=0x3, data 0xA5A5 -> slv_sel=0b1000, slv_wren=0x3, slv_do=0xA5A5; cpu_mem_rdy after slave3 rdy, cpu_di=0.
REQ-031 Read 0x40000000 (unmapped) -> no slv_sel, cpu_mem_rdy 1 cycle after request, cpu_err=1, cpu_di=0.
REQ-032 BUS_TIMEOUT_EN, TIMEOUT=8, slave1 never ready on 0x00020000 -> cpu_mem_rdy with cpu_err=1 after 8 ACCESS cycles.
REQ-033 Reset low during ACCESS on slave2 -> slv_sel=0, cpu_mem_rdy=0 immediately; next request after reset decodes normally.
REQ-034 Slave0 rdy asserted while slave1 is selected -> ignored; completion only on slave1 rdy, its data returned.
